// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and PC source selects.
// Opcode values match the single-cycle decoder so both cores can share mcu_alu_decode.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Bundle between the control unit (master) and the datapath/IR/memory side (slave).
interface multi_cycle_control_unit_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
);
    logic [OP_W-1:0]    op;
    logic               zero;
    logic               mem_ready;
    logic               PCWrite;
    logic               IRWrite;
    logic               InsMemRW;
    logic               ExtSrc;
    logic               RegDst;
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic [1:0]         PCSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic [3:0]         state;
    logic               halted;
    logic               mem_timeout;
    logic               illegal_op;

    modport master (
        input  op, zero, mem_ready,
        output PCWrite, IRWrite, InsMemRW, ExtSrc, RegDst, RegWrite, MemRead, MemWrite,
               MemtoReg, PCSrc, ALUOp, state, halted, mem_timeout, illegal_op
    );

    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, IRWrite, InsMemRW, ExtSrc, RegDst, RegWrite, MemRead, MemWrite,
               MemtoReg, PCSrc, ALUOp, state, halted, mem_timeout, illegal_op
    );
endinterface

// File: rtl/multi_cycle_control_unit_alu_decode.sv
// Combinational opcode decode to ALU function, immediate extension mode and destination select.
// Shared with the single-cycle decoder, so the encodings here must not drift.
module mcu_alu_decode
    import mcu_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
) (
    input  logic [OP_W-1:0]    i_op,
    output logic [ALUOP_W-1:0] o_alu_op,
    output logic               o_ext_src,
    output logic               o_reg_dst
);

    logic [5:0] w_op;
    logic [3:0] w_alu;

    assign w_op = 6'(i_op);

    always_comb begin
        w_alu[3] = (w_op == OP_RTYPE);
        w_alu[2] = (w_op == OP_SLTI) || (w_op == OP_BLTZ);
        w_alu[1] = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_BLTZ);
        w_alu[0] = (w_op == OP_ORI) || (w_op == OP_SLTI) || (w_op == OP_BEQ) || (w_op == OP_BNE);
    end

    assign o_alu_op  = ALUOP_W'(w_alu);
    // Logical immediates are zero-extended; everything else sign-extends.
    assign o_ext_src = !((w_op == OP_ANDI) || (w_op == OP_ORI));
    assign o_reg_dst = (w_op == OP_RTYPE);

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle CPU control FSM: steps each instruction through IF/ID/EXE/MEM/WB, drives datapath
// enables as Moore outputs, and guards data-memory accesses with a bounded ready wait.
module multi_cycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int ALUOP_W       = 4,
    parameter int MEM_HANDSHAKE = 1,
    parameter int MAX_WAIT      = 15,
    parameter int WAIT_W        = 4
) (
    input  logic                        CLK,
    input  logic                        Reset,
    multi_cycle_control_unit_if.master  io_ctl
);

    state_t              r_state;
    state_t              w_next_state;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_timeout;
    logic [5:0]          w_op;
    logic                w_done;
    logic                w_timeout_hit;
    logic                w_known_op;
    logic                w_br_taken;
    logic [ALUOP_W-1:0]  w_alu_op;
    logic                w_ext_src;
    logic                w_reg_dst;

    mcu_alu_decode #(
        .OP_W    (OP_W),
        .ALUOP_W (ALUOP_W)
    ) u_alu_decode (
        .i_op     (io_ctl.op),
        .o_alu_op (w_alu_op),
        .o_ext_src(w_ext_src),
        .o_reg_dst(w_reg_dst)
    );

    assign w_op          = 6'(io_ctl.op);
    assign w_done        = (MEM_HANDSHAKE != 0) ? io_ctl.mem_ready : 1'b1;
    // A ready arriving in the same cycle as the timeout still completes the access.
    assign w_timeout_hit = (r_state == S_MEM) && !w_done && (r_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_br_taken    = (((w_op == OP_BEQ) || (w_op == OP_BLTZ)) && io_ctl.zero)
                         || ((w_op == OP_BNE) && !io_ctl.zero);
    assign w_known_op    = (w_op == OP_RTYPE) || (w_op == OP_J)    || (w_op == OP_BEQ)
                         || (w_op == OP_BNE)  || (w_op == OP_BLTZ) || (w_op == OP_ADDI)
                         || (w_op == OP_SLTI) || (w_op == OP_ANDI) || (w_op == OP_ORI)
                         || (w_op == OP_LW)   || (w_op == OP_SW)   || (w_op == OP_HALT);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= S_IF;
        else       r_state <= w_next_state;
    end

    // Counter is held at zero outside MEM, so every MEM visit starts fresh.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != S_MEM) begin
            r_wait_cnt <= '0;
        end else if (!w_done && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)              r_mem_timeout <= 1'b0;
        else if (w_timeout_hit) r_mem_timeout <= 1'b1;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IF: w_next_state = S_ID;
            S_ID: begin
                if (w_op == OP_HALT)                          w_next_state = S_HALT;
                else if ((w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_BLTZ))
                                                              w_next_state = S_EXE_BR;
                else if ((w_op == OP_LW) || (w_op == OP_SW))  w_next_state = S_EXE_LS;
                else if ((w_op == OP_RTYPE) || (w_op == OP_ADDI) || (w_op == OP_SLTI)
                      || (w_op == OP_ANDI) || (w_op == OP_ORI))
                                                              w_next_state = S_EXE_AL;
                else                                          w_next_state = S_IF;
            end
            S_EXE_AL: w_next_state = S_WB_AL;
            S_EXE_BR: w_next_state = S_IF;
            S_EXE_LS: w_next_state = S_MEM;
            S_MEM: begin
                if (w_done)             w_next_state = (w_op == OP_LW) ? S_WB_LD : S_IF;
                else if (w_timeout_hit) w_next_state = S_HALT;
            end
            S_WB_AL:  w_next_state = S_IF;
            S_WB_LD:  w_next_state = S_IF;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IF;
        endcase
    end

    always_comb begin
        io_ctl.PCWrite    = 1'b0;
        io_ctl.IRWrite    = 1'b0;
        io_ctl.InsMemRW   = 1'b0;
        io_ctl.ExtSrc     = w_ext_src;
        io_ctl.RegDst     = 1'b0;
        io_ctl.RegWrite   = 1'b0;
        io_ctl.MemRead    = 1'b0;
        io_ctl.MemWrite   = 1'b0;
        io_ctl.MemtoReg   = 1'b0;
        io_ctl.PCSrc      = PC_SEQ;
        io_ctl.ALUOp      = '0;
        io_ctl.illegal_op = 1'b0;
        case (r_state)
            S_IF: begin
                io_ctl.InsMemRW = 1'b1;
                io_ctl.IRWrite  = 1'b1;
            end
            S_ID: begin
                if (w_op == OP_J) begin
                    io_ctl.PCSrc   = PC_JMP;
                    io_ctl.PCWrite = 1'b1;
                end else if (!w_known_op) begin
                    io_ctl.illegal_op = 1'b1;
                    io_ctl.PCWrite    = 1'b1;
                end
            end
            S_EXE_AL: io_ctl.ALUOp = w_alu_op;
            S_EXE_BR: begin
                io_ctl.ALUOp   = w_alu_op;
                io_ctl.PCSrc   = w_br_taken ? PC_BR : PC_SEQ;
                io_ctl.PCWrite = 1'b1;
            end
            S_MEM: begin
                io_ctl.MemRead  = (w_op == OP_LW) && !w_timeout_hit;
                io_ctl.MemWrite = (w_op != OP_LW) && !w_timeout_hit;
                io_ctl.PCWrite  = (w_op != OP_LW) && w_done;
            end
            S_WB_AL: begin
                io_ctl.RegWrite = 1'b1;
                io_ctl.RegDst   = w_reg_dst;
                io_ctl.PCWrite  = 1'b1;
            end
            S_WB_LD: begin
                io_ctl.RegWrite = 1'b1;
                io_ctl.MemtoReg = 1'b1;
                io_ctl.PCWrite  = 1'b1;
            end
            default: ;
        endcase
        // Nothing may be written while Reset is held, including the IR fetch in IF.
        if (Reset) begin
            io_ctl.PCWrite  = 1'b0;
            io_ctl.IRWrite  = 1'b0;
            io_ctl.RegWrite = 1'b0;
            io_ctl.MemRead  = 1'b0;
            io_ctl.MemWrite = 1'b0;
        end
    end

    assign io_ctl.state       = r_state;
    assign io_ctl.halted      = (r_state == S_HALT);
    assign io_ctl.mem_timeout = r_mem_timeout;

endmodule
